// File: rtl/iterative_multiplier.sv
// Iterative shift-add unsigned multiplier.
// Accepts one operand pair at a time, retires one multiplier bit per clock and
// holds the full 2*WIDTH-bit product until the consumer takes it.
module iterative_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    // Counter must be able to hold the value WIDTH itself
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a_reg;
    logic               accept;
    logic               operand_zero;
    logic               last_step;
    logic [WIDTH:0]     partial_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Handshake qualifiers and the zero-operand shortcut test
    always_comb begin
        accept       = in_valid && in_ready;
        operand_zero = (a == '0) || (b == '0);
        last_step    = (count == CNT_W'(1));
    end

    // One shift-add step: the carry out of the upper-half add is kept and
    // shifted into the top bit so no product bit is ever lost
    always_comb begin
        partial_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            partial_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_reg};
        end
        acc_step = {partial_sum, acc[WIDTH-1:1]};
    end

    // State register; reset wins over any handshake on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = operand_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, iterate while running, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            count <= '0;
            acc   <= '0;
        end else if (accept) begin
            a_reg <= a;
            count <= CNT_W'(WIDTH);
            acc   <= operand_zero ? '0 : {{WIDTH{1'b0}}, b};
        end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count - CNT_W'(1);
        end
    end

    // Product is only exposed while the result is being offered
    always_comb begin
        product = '0;
        if (state == DONE) begin
            product = acc;
        end
    end

endmodule

// File: doc/iterative_multiplier.md
ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  multiplicand, unsigned.
REQ-007 b  input  WIDTH  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  2*WIDTH  unsigned a*b.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 Outputs by state SHALL be:
- in_ready=1 only in IDLE.
- out_valid=1 only in DONE.
- busy=1 in RUN and DONE.
REQ-014 Input handshake: an accept SHALL occur on a rising edge where in_valid=1 and in_ready=1. On accept, a and b SHALL be captured internally, the step counter SHALL be loaded with WIDTH, and the accumulator SHALL be loaded as {WIDTH zeros, b}.
REQ-015 Zero shortcut: if a==0 or b==0 at accept, the FSM SHALL go IDLE->DONE with product=0, so out_valid is high 1 cycle after the accept edge.
REQ-016 Otherwise the FSM SHALL go IDLE->RUN.
REQ-017 Each RUN cycle SHALL perform one shift-add step:
- if acc[0]=1, add the captured a to acc[2W-1:W] using a W+1-bit sum that keeps the carry;
- shift {carry, acc} right by 1;
- decrement the counter.
REQ-018 When the counter reaches 0, the FSM SHALL go RUN->DONE. out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-019 The product SHALL be exact modulo nothing: a full 2*WIDTH-bit result with no overflow, e.g. max*max = 2^(2W) - 2^(W+1) + 1.
REQ-020 Changes on a, b or in_valid after accept SHALL NOT affect the result or the state.
REQ-021 In DONE, product and out_valid SHALL be held stable while out_ready=0, for an unbounded time.
REQ-022 On an edge in DONE with out_ready=1, the FSM SHALL go DONE->IDLE. in_ready SHALL be 1 in the following cycle. No new accept SHALL occur in the same cycle as the output handshake.
REQ-023 in_valid asserted in RUN or DONE SHALL be ignored (no queuing). The upstream stage holds its data until in_ready=1.
REQ-024 product SHALL read 0 in IDLE and RUN, and equals the accumulator only in DONE.
REQ-025 out_ready in IDLE or RUN SHALL have no effect.

Reset
REQ-026 When rst=1 on a rising edge, the block SHALL enter IDLE with counter=0, accumulator=0, captured operand=0, in_ready=1, out_valid=0, busy=0, product=0, regardless of the current state.
REQ-027 rst SHALL take priority over any simultaneous in_valid or out_ready handshake. An operation in flight at reset SHALL be discarded and produce no output.
REQ-028 In the first cycle after rst deasserts, the block SHALL be able to accept an operand pair.

Verification (WIDTH=32)
REQ-029 a=3, b=5, in_valid pulsed for 1 cycle, out_ready=1 -> out_valid rises 32 cycles after accept with product=15; in_ready=1 one cycle after the output handshake.
REQ-030 a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 after 32 cycles; a=0x80000000, b=2 -> 0x0000000100000000.
REQ-031 a=0, b=0x1234 -> out_valid 1 cycle after accept with product=0; repeat with a=0x1234, b=0 -> same response.
REQ-032 a=7, b=6, out_ready held 0 for 5 cycles after out_valid rises -> out_valid=1 and product=42 stay stable throughout; in_ready=0 throughout; handshake on cycle 6.
REQ-033 Accept a=9, b=9, then drive in_valid=1 with a=1, b=1 during RUN and flip a/b every cycle -> result is 81; the second pair is accepted only after return to IDLE and yields 1.
REQ-034 rst asserted at RUN step 10 -> next cycle in_ready=1, out_valid=0, busy=0, product=0; no stale out_valid afterwards; a following a=4, b=4 yields 16 after 32 cycles.
